pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised pipeline register chain: DEPTH stages of WIDTH-bit data, each with a valid bit.
- Valid/ready handshake; bubble-collapsing, so an empty stage always accepts even when the output is stalled.
- Synchronous flush for branch/exception squash.
- Generalised successor to the single-bit D flip-flop; used between MIPS pipeline stages (IF/ID, ID/EX, ...).

Parameters:
- WIDTH, 32, data bits per stage (>=1)
- DEPTH, 1, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every stage data register on reset or flush (WIDTH bits)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  upstream data valid
- in_ready  output  1  chain can accept in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  data of stage DEPTH-1

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clock and reset.
- Stage state:
  - Stage k (0..DEPTH-1) holds v[k] and d[k]. Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data directly (no output combinational logic).
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
  - rdy[k] = !v[k] | rdy[k+1]
  - in_ready = rdy[0]
  - No ready->valid combinational path from in_valid to in_ready.
- Clock edge, when not in reset/flush, for each stage k with rdy[k]=1:
  - Stage 0: v[0] <= in_valid; d[0] <= in_data only when in_valid=1.
  - Stage k>0: v[k] <= v[k-1]; d[k] <= d[k-1] only when v[k-1]=1.
  - Stages with rdy[k]=0 hold both v and d.
- Transfer rules:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - Latency with no stalls: exactly DEPTH cycles from input transfer to out_valid.
  - Throughput: 1 item per cycle.
- Ordering: strict FIFO. No item is dropped or duplicated; capacity is DEPTH items.
- Stall:
  - out_ready=0 with all stages valid: in_ready=0 and all state holds.
  - out_ready=0 with a hole in the chain: items upstream of the hole advance to fill it (bubble collapse).
- Reset (clock edge with reset=1): all v <= 0, all d <= RESET_VAL; out_valid=0 and out_data=RESET_VAL in the following cycle. Reset mid-transfer discards all in-flight items, and the concurrent input transfer is ignored.
- Flush (clock edge with flush=1, reset=0): identical to reset, including discarding a same-cycle input.
- Priority: reset > flush > normal.
- Simultaneous out and in transfer on a full chain: allowed, since ready propagates backward; occupancy is unchanged.
- in_valid without in_ready: upstream must hold in_data stable. The block does not check this.

Optional Feature:
- Macro: PIPE_REG_CHAIN_OCC_EN.
- When defined:
  - Adds output port occupancy, width $clog2(DEPTH+1), equal to the count of set v[k]. Registered; updated on the same edges as v.
  - Reset and flush both load 0.
- When undefined: port absent, no counter logic.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF, DEPTH=3, RESET_VAL=32'h0 -> out_valid=0 and out_data=0 throughout and 1 cycle after release; no item emerges.
- Streaming: DEPTH=3, out_ready=1, feed 1,2,3,4,5 on consecutive cycles -> out_valid rises exactly 3 cycles after the first transfer; outputs 1..5 on consecutive cycles, in order.
- Backpressure: DEPTH=3, out_ready=0, feed 10,11,12,13 -> in_ready=0 after 3 accepts, 13 not accepted, out_data=10. Raise out_ready -> 10,11,12 then 13 emerge; none lost.
- Bubble collapse: DEPTH=4, out_ready=0, feed A, gap, B -> B advances until adjacent to A; in_ready stays 1 until 4 items are held.
- Flush: DEPTH=2, with 2 items held, pulse flush with in_valid=1 and in_data=7 -> next cycle out_valid=0, out_data=RESET_VAL, 7 not captured; flush and reset together behave as reset.
- PIPE_REG_CHAIN_OCC_EN, DEPTH=4: occupancy tracks 0->1->2->3->4 while filling with out_ready=0; stays 4 with simultaneous in/out transfers; returns to 0 on flush.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain: DEPTH valid/data stages, valid/ready handshake,
// bubble collapse and synchronous flush. Define PIPE_REG_CHAIN_OCC_EN to add an occupancy count.
module pipe_reg_chain #(
    parameter int              WIDTH     = 32,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] rdy_s;
    logic [DEPTH-1:0] up_v_s;
    logic [WIDTH-1:0] d_q    [DEPTH];
    logic [WIDTH-1:0] d_d    [DEPTH];
    logic [WIDTH-1:0] up_d_s [DEPTH];

    // Backward ready chain and the upstream source feeding each stage
    always_comb begin
        rdy_s  = {DEPTH{1'b0}};
        up_v_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            up_d_s[k] = {WIDTH{1'b0}};
        end
        // A stage is ready if it is empty or anything downstream can move.
        rdy_s[DEPTH-1] = !v_q[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            rdy_s[k] = !v_q[k] | rdy_s[k+1];
        end
        up_v_s[0] = in_valid;
        up_d_s[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v_s[k] = v_q[k-1];
            up_d_s[k] = d_q[k-1];
        end
    end

    // Next-state: a ready stage takes its upstream valid, and data only when that is valid
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (rdy_s[k]) begin
                v_d[k] = up_v_s[k];
                if (up_v_s[k]) begin
                    d_d[k] = up_d_s[k];
                end else begin
                    d_d[k] = d_q[k];
                end
            end else begin
                v_d[k] = v_q[k];
                d_d[k] = d_q[k];
            end
        end
    end

    // Stage registers; reset and flush have the same clearing effect
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            v_q <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RESET_VAL;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    function automatic logic [OCC_W-1:0] count_valid(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] n;
        n = {OCC_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            n = n + OCC_W'(v[k]);
        end
        return n;
    endfunction

    // Count of valid stages after the coming edge
    always_comb begin
        occ_d = count_valid(v_d);
    end

    // Occupancy register, cleared alongside the stages
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed scenarios then randomized traffic,
// checked against a position-based item model of the chain.
module tb_pipe_reg_chain;

    localparam int          WIDTH     = 32;
    localparam int          DEPTH     = 3;
    localparam logic [31:0] RESET_VAL = 32'h0BAD_F00D;

    logic             clock;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

    pipe_reg_chain #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
        ,
        .occupancy(occupancy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each in-flight item with the stage position it currently occupies; index 0 is oldest.
    typedef struct {
        logic [31:0] data;
        int          pos;
    } item_t;

    item_t       items[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_out = RESET_VAL;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an item advances if a hole exists ahead of it or the output drains.
    initial begin
        item_t nxt[$];
        item_t it;
        bit    accept;
        int    p;
        forever begin
            @(posedge clock);
            if (reset || flush) begin
                items.delete();
                exp_q.delete();
                last_out = RESET_VAL;
            end else begin
                accept = in_valid && ((items.size() < DEPTH) || out_ready);
                nxt.delete();
                foreach (items[i]) begin
                    p = items[i].pos;
                    if (p == DEPTH - 1) begin
                        if (!out_ready) nxt.push_back(items[i]);
                    end else if ((i < DEPTH - 1 - p) || out_ready) begin
                        it     = items[i];
                        it.pos = p + 1;
                        if (it.pos == DEPTH - 1) last_out = it.data;
                        nxt.push_back(it);
                    end else begin
                        nxt.push_back(items[i]);
                    end
                end
                if (accept) begin
                    it.data = in_data;
                    it.pos  = 0;
                    if (DEPTH == 1) last_out = in_data;
                    nxt.push_back(it);
                    exp_q.push_back(in_data);
                end
                items = nxt;
            end
        end
    end

    // Monitor: compare handshake/status every cycle, pop scoreboard on output transfers
    initial begin
        bit          m_valid;
        logic [31:0] exp_data;
        @(posedge clock);
        forever begin
            @(negedge clock);
            m_valid = (items.size() > 0) && (items[0].pos == DEPTH - 1);
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("in_ready", 64'(in_ready), 64'((items.size() < DEPTH) || out_ready));
            check("out_data_reg", 64'(out_data), 64'(last_out));
`ifdef PIPE_REG_CHAIN_OCC_EN
            check("occupancy", 64'(occupancy), 64'(items.size()));
`endif
            if (out_valid && out_ready) begin
                check("output_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    exp_data = exp_q.pop_front();
                    check("sb_data", 64'(out_data), 64'(exp_data));
                end
            end
        end
    end

    task automatic drive(input bit iv, input logic [31:0] id, input bit ordy,
                         input bit fl, input bit rs);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held two cycles with a valid input present
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming 1..5
        for (int v = 1; v <= 5; v++) drive(1'b1, 32'(v), 1'b1, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: 13 refused until the output drains
        for (int v = 10; v <= 12; v++) drive(1'b1, 32'(v), 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 32'd13, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd13, 1'b1, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Bubble collapse under a stalled output
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with a same-cycle input, then flush and reset together
        drive(1'b1, 32'd21, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd7,  1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd31, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd32, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd8,  1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Full chain with simultaneous in/out transfers
        repeat (DEPTH) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        repeat (8) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);

        // Randomized traffic: mostly flowing, then mostly stalled
        repeat (600) drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                           ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0));
        repeat (300) drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 3),
                           ($urandom_range(0, 79) == 0), 1'b0);

        repeat (DEPTH + 4) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
